alu_pipe: RTL

Parametrised, pipelined successor to the team's 32-bit combinational ALU. It keeps the same 3-bit opcode map and zero/equal/overflow flag semantics, and generalises the datapath width. It adds a two-stage registered pipeline with valid/ready flow control, an illegal-opcode flag, and a sticky overflow status bit. It sits between the issue logic and writeback in the execute path.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 50 +++++
 rtl/alu_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and flag types for the ALU family
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_SLT = 3'b011,
    OP_SRL = 3'b100,
    OP_SRA = 3'b101,
    OP_SLL = 3'b110,
    OP_RSV = 3'b111
  } op_t;

  typedef struct packed {
    logic zero;
    logic equal;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath and result flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  op_t              op_i,
  output logic [WIDTH-1:0] z_o,
  output flags_t           flags_o
);

  logic             is_sub;
  logic             is_arith;
  logic             illegal;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_ext;
  logic             msb_cin;
  logic [SHW-1:0]   amt;

  always_comb begin
    is_sub   = (op_i == OP_SUB);
    is_arith = (op_i == OP_ADD) || is_sub;
    illegal  = (op_i == OP_RSV);
    // SUB shares the adder as x + ~y + 1
    b_op     = is_sub ? ~y_i : y_i;
    sum_ext  = {1'b0, x_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    msb_cin  = x_i[WIDTH-1] ^ b_op[WIDTH-1] ^ sum_ext[WIDTH-1];
    amt      = y_i[SHW-1:0];

    z_o = '0;
    case (op_i)
      OP_AND:         z_o = x_i & y_i;
      OP_ADD, OP_SUB: z_o = sum_ext[WIDTH-1:0];
      OP_SLT:         z_o = {{(WIDTH-1){1'b0}}, ($signed(x_i) < $signed(y_i))};
      OP_SRL:         z_o = x_i >> amt;
      OP_SRA:         z_o = $unsigned($signed(x_i) >>> amt);
      OP_SLL:         z_o = x_i << amt;
      default:        z_o = '0;
    endcase

    flags_o.illegal  = illegal;
    flags_o.overflow = is_arith & (msb_cin ^ sum_ext[WIDTH]);
    flags_o.zero     = !illegal && (z_o == '0);
    flags_o.equal    = !illegal && (x_i == y_i);
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage registered ALU with valid/ready handshake and sticky overflow
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             equal,
  output logic             overflow,
  output logic             illegal,
  output logic             sticky_ovf,
  input  logic             clr_sticky
);

  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  op_t              op_q, op_d;
  flags_t           flags_q, flags_d;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic             sticky_q, sticky_d;
  logic             s2_free, s1_adv, accept;
  logic [WIDTH-1:0] core_z;
  flags_t           core_flags;

  alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
    .x_i     (x_q),
    .y_i     (y_q),
    .op_i    (op_q),
    .z_o     (core_z),
    .flags_o (core_flags)
  );

  always_comb begin
    s2_free    = !s2_valid_q || out_ready;
    s1_adv     = s1_valid_q && s2_free;
    in_ready   = !s1_valid_q || s1_adv;
    accept     = in_valid && in_ready;

    s1_valid_d = accept || (s1_valid_q && !s1_adv);
    s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
    x_d        = accept ? x : x_q;
    y_d        = accept ? y : y_q;
    op_d       = accept ? op_t'(op) : op_q;
    z_d        = s1_adv ? core_z : z_q;
    flags_d    = s1_adv ? core_flags : flags_q;
    // A setting transfer beats a simultaneous clear
    sticky_d   = (s2_valid_q && out_ready && flags_q.overflow) || (sticky_q && !clr_sticky);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      op_q       <= OP_AND;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      flags_q    <= '0;
      sticky_q   <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      op_q       <= op_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
      flags_q    <= flags_d;
      sticky_q   <= sticky_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign z          = z_q;
  assign zero       = flags_q.zero;
  assign equal      = flags_q.equal;
  assign overflow   = flags_q.overflow;
  assign illegal    = flags_q.illegal;
  assign sticky_ovf = sticky_q;

endmodule
